chan_sel_pipe: RTL and testbench
================================

// Module: chan_sel_pipe
// PURPOSE
//  Parametrised, registered N-channel stream selector: successor to the single-bit case/function select.
//  Routes one of NCH valid/ready input channels to one output through a single register stage.
//  Channel choice is either a fixed SEL (case select, out-of-range takes the default branch) or a round-robin scan.
//  Sits between per-channel producers and a single downstream consumer.
// PARAMETERS
//  NCH    4  number of input channels (>=2)
//  WIDTH  8  data width per channel
//  SELW   2  select/pointer width; must satisfy 2**SELW >= NCH
// PORTS
//  CLK       in   1          clock, all state on rising edge
//  RST       in   1          reset, asynchronous, active-high
//  IN_DATA   in   NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  IN_VALID  in   NCH        per-channel valid
//  IN_READY  out  NCH        per-channel ready (combinational)
//  SEL       in   SELW       fixed-mode channel select
//  MODE      in   1          0 = fixed (SEL), 1 = round-robin scan
//  ERR_CLR   in   1          clears ERR
//  OUT_DATA  out  WIDTH      registered data
//  OUT_CH    out  SELW       source channel of OUT_DATA
//  OUT_VALID out  1          output holds a word
//  OUT_READY in   1          downstream accepts
//  ERR       out  1          sticky: fixed-mode SEL >= NCH seen
// BEHAVIOUR
//  Reset (async, RST=1): OUT_VALID=0, OUT_DATA=0, OUT_CH=0, ERR=0, PTR=0; IN_READY=0 while RST=1.
//  Grant channel G: MODE=0 -> G=SEL; MODE=1 -> G=PTR. Decode is a case on G; default (G>=NCH) -> no grant.
//  Stage free: FREE = !OUT_VALID || OUT_READY.
//  IN_READY[i] = (i==G) && G<NCH && FREE; all other bits 0. No grant -> IN_READY all 0.
//  Input transfer: IN_VALID[G] && IN_READY[G]. Then, next edge: OUT_DATA=IN_DATA[G], OUT_CH=G, OUT_VALID=1.
//  Latency: one cycle, input handshake to OUT_VALID.
//  Output transfer: OUT_VALID && OUT_READY. With no new input in the same cycle -> OUT_VALID=0.
//  Simultaneous output and input transfer -> stage refills; OUT_VALID stays 1; full throughput, 1 word/cycle.
//  OUT_VALID && !OUT_READY: OUT_DATA and OUT_CH hold stable; no input is accepted.
//  Channels not granted are never consumed; their IN_VALID may stay high indefinitely.
//  Fixed mode, SEL>=NCH: no transfer; ERR sets on the next edge. Pending output still drains normally.
//  ERR: stays 1 until ERR_CLR=1 at an edge. If a set condition and ERR_CLR coincide, the set wins.
//  Round-robin, PTR update (MODE=1 only):
//   - PTR advances by one when an input transfer occurs, or when IN_VALID[PTR]=0 (skip idle channel).
//   - PTR holds when IN_VALID[PTR]=1 but !FREE (backpressure).
//   - Wrap: PTR=NCH-1 advances to 0. PTR never takes a value >= NCH.
//  MODE change is sampled each cycle; PTR keeps its value across mode changes. An in-flight output word is unaffected.
//  Reset mid-transfer: the held output word is discarded; no partial state survives.
// TESTING
//  1 Reset: RST pulse with OUT_VALID=1 -> OUT_VALID=0, ERR=0, IN_READY=0 asynchronously.
//  2 Fixed: MODE=0, SEL=2, IN_DATA ch2=8'hA5, IN_VALID=4'b0100, OUT_READY=1
//    -> IN_READY=4'b0100; next cycle OUT_DATA=A5, OUT_CH=2, OUT_VALID=1.
//  3 Backpressure: OUT_READY=0 for 3 cycles, ch2 streaming 01,02,03 -> OUT_DATA holds 01,
//    IN_READY=0; release -> 02,03 delivered in order, no loss or duplication.
//  4 Round-robin: MODE=1, all channels valid, data = channel index, OUT_READY=1
//    -> OUT_CH sequence 0,1,2,3,0,...; one word per cycle.
//  5 Skip: MODE=1, IN_VALID=4'b1001 -> OUT_CH alternates 0,3; PTR wraps 3->0.
//  6 Error: NCH=3, SELW=2, MODE=0, SEL=3 -> IN_READY=0, ERR=1 next edge; stays 1 until ERR_CLR pulse.

Source files
------------

// File: rtl/chan_sel_pipe.sv
// Registered N-channel valid/ready stream selector.
// The granted channel comes from a fixed select or from a round-robin scan pointer.
module chan_sel_pipe #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant;
  logic [NCH-1:0]   hit;
  logic             grant_ok;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;
  logic             free;
  logic             take;

  assign grant = mode ? ptr : sel;
  assign free  = !out_valid || out_ready;

  // Grant decode: an out-of-range grant matches no channel, so nothing is offered.
  always_comb begin
    hit         = '0;
    grant_ok    = 1'b0;
    grant_valid = 1'b0;
    grant_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        hit[i]      = 1'b1;
        grant_ok    = 1'b1;
        grant_valid = in_valid[i];
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = !rst && hit[i] && free;
    end
  end

  assign take = grant_ok && free && grant_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A new out-of-range select beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (!mode && !grant_ok) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Scan pointer moves past idle or just-served channels, holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (mode && (take || !grant_valid)) begin
      if (ptr == SELW'(NCH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chan_sel_pipe.sv
// Randomised and directed checks of chan_sel_pipe (NCH=4 and NCH=3 instances)
// against a transaction-level model of the selector.
module tb_chan_sel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        mode;
  logic        err_clr;
  logic        out_ready;

  logic [3:0]  in_ready4;
  logic [7:0]  out_data4;
  logic [1:0]  out_ch4;
  logic        out_valid4;
  logic        err4;

  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        err3;

  int vectors     = 0;
  int miscompares = 0;
  int checks      = 0;

  typedef struct {
    bit       ov;
    bit [7:0] od;
    bit [1:0] oc;
    bit       err;
    int       ptr;
  } mstate_t;

  mstate_t m4, m3;

  always #5 clk = ~clk;

  chan_sel_pipe #(.NCH(4), .WIDTH(8), .SELW(2)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .sel(sel), .mode(mode), .err_clr(err_clr), .out_data(out_data4), .out_ch(out_ch4),
    .out_valid(out_valid4), .out_ready(out_ready), .err(err4)
  );

  chan_sel_pipe #(.NCH(3), .WIDTH(8), .SELW(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(in_ready3),
    .sel(sel), .mode(mode), .err_clr(err_clr), .out_data(out_data3), .out_ch(out_ch3),
    .out_valid(out_valid3), .out_ready(out_ready), .err(err3)
  );

  function automatic int grantOf(mstate_t s, bit md, bit [1:0] sl);
    return md ? s.ptr : int'(sl);
  endfunction

  function automatic bit [3:0] readyOf(mstate_t s, int nch, bit md, bit [1:0] sl, bit ordy);
    int g = grantOf(s, md, sl);
    bit [3:0] r = '0;
    if (g < nch && (!s.ov || ordy)) r[g] = 1'b1;
    return r;
  endfunction

  // One clock edge of the selector, described as a word moving through a one-deep stage.
  function automatic mstate_t step(mstate_t s, int nch, bit [3:0] v, bit [31:0] d,
                                   bit [1:0] sl, bit md, bit ordy, bit eclr);
    mstate_t n = s;
    int g = grantOf(s, md, sl);
    bit acc = (g < nch) && (!s.ov || ordy) && v[g];
    if (acc) begin
      n.ov = 1'b1;
      n.od = d[g*8 +: 8];
      n.oc = 2'(g);
    end else if (ordy) begin
      n.ov = 1'b0;
    end
    if (!md && g >= nch) n.err = 1'b1;
    else if (eclr) n.err = 1'b0;
    if (md && (acc || !v[g])) n.ptr = (s.ptr + 1) % nch;
    return n;
  endfunction

  task automatic cmp(string what, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", what, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit [3:0] r4;
    bit [3:0] r3;
    r4 = readyOf(m4, 4, mode, sel, out_ready);
    r3 = readyOf(m3, 3, mode, sel, out_ready);
    cmp("out_valid4", 32'(out_valid4), 32'(m4.ov));
    cmp("err4", 32'(err4), 32'(m4.err));
    cmp("in_ready4", 32'(in_ready4), 32'(r4));
    if (m4.ov) begin
      cmp("out_data4", 32'(out_data4), 32'(m4.od));
      cmp("out_ch4", 32'(out_ch4), 32'(m4.oc));
    end
    cmp("out_valid3", 32'(out_valid3), 32'(m3.ov));
    cmp("err3", 32'(err3), 32'(m3.err));
    cmp("in_ready3", 32'(in_ready3), 32'(r3[2:0]));
    if (m3.ov) begin
      cmp("out_data3", 32'(out_data3), 32'(m3.od));
      cmp("out_ch3", 32'(out_ch3), 32'(m3.oc));
    end
  endtask

  // Drive one cycle of inputs, compare everything against the model, then advance the model.
  task automatic applyStimulus(bit [3:0] v, bit [31:0] d, bit [1:0] sl, bit md, bit ordy, bit eclr);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    sel       = sl;
    mode      = md;
    out_ready = ordy;
    err_clr   = eclr;
    #1;
    checkOutput();
    m4 = step(m4, 4, v, d, sl, md, ordy, eclr);
    m3 = step(m3, 3, v, d, sl, md, ordy, eclr);
    vectors++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    sel       = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    m4 = '{ov: 1'b0, od: 8'h00, oc: 2'd0, err: 1'b0, ptr: 0};
    m3 = m4;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seen;
    int expCh;

    rst = 1'b0;
    doReset();

    // Asynchronous reset while a word is held and an error is pending
    applyStimulus(4'b1000, 32'h11223344, 2'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 32'h11223344, 2'd3, 1'b0, 1'b1, 1'b0);
    cmp("pre-reset out_valid4", 32'(out_valid4), 32'd1);
    cmp("pre-reset err3", 32'(err3), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    cmp("async out_valid4", 32'(out_valid4), 32'd0);
    cmp("async err3", 32'(err3), 32'd0);
    cmp("async in_ready4", 32'(in_ready4), 32'd0);
    doReset();

    // Fixed select of channel 2
    applyStimulus(4'b0100, 32'h00A50000, 2'd2, 1'b0, 1'b1, 1'b0);
    cmp("fixed in_ready4", 32'(in_ready4), 32'h4);
    applyStimulus(4'b0000, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0);
    cmp("fixed out_data4", 32'(out_data4), 32'hA5);
    cmp("fixed out_ch4", 32'(out_ch4), 32'd2);
    cmp("fixed out_valid4", 32'(out_valid4), 32'd1);

    // Backpressure on channel 2
    doReset();
    applyStimulus(4'b0100, 32'h00010000, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0100, 32'h00020000, 2'd2, 1'b0, 1'b0, 1'b0);
      cmp("bp hold data", 32'(out_data4), 32'h01);
      cmp("bp in_ready4", 32'(in_ready4), 32'h0);
    end
    applyStimulus(4'b0100, 32'h00020000, 2'd2, 1'b0, 1'b1, 1'b0);
    cmp("bp release data", 32'(out_data4), 32'h01);
    applyStimulus(4'b0100, 32'h00030000, 2'd2, 1'b0, 1'b1, 1'b0);
    cmp("bp second word", 32'(out_data4), 32'h02);
    applyStimulus(4'b0000, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0);
    cmp("bp third word", 32'(out_data4), 32'h03);
    applyStimulus(4'b0000, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0);
    cmp("bp drained", 32'(out_valid4), 32'd0);

    // Round-robin with all channels busy: one word per cycle in channel order
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'b1111, 32'h03020100, 2'd0, 1'b1, 1'b1, 1'b0);
      if (k > 0) begin
        cmp("rr out_valid4", 32'(out_valid4), 32'd1);
        cmp("rr out_ch4", 32'(out_ch4), 32'((k - 1) % 4));
        cmp("rr out_data4", 32'(out_data4), 32'((k - 1) % 4));
      end
    end

    // Round-robin skipping idle channels 1 and 2
    doReset();
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(4'b1001, 32'h03020100, 2'd0, 1'b1, 1'b1, 1'b0);
      if (out_valid4) begin
        expCh = (seen % 2 == 0) ? 0 : 3;
        cmp("skip out_ch4", 32'(out_ch4), 32'(expCh));
        seen++;
      end
    end
    cmp("skip word count", 32'(seen >= 6), 32'd1);

    // Out-of-range select on the three-channel instance
    doReset();
    applyStimulus(4'b1111, 32'h03020100, 2'd3, 1'b0, 1'b1, 1'b0);
    cmp("err in_ready3", 32'(in_ready3), 32'h0);
    applyStimulus(4'b1111, 32'h03020100, 2'd3, 1'b0, 1'b1, 1'b0);
    cmp("err set", 32'(err3), 32'd1);
    applyStimulus(4'b1111, 32'h03020100, 2'd3, 1'b0, 1'b1, 1'b1);
    cmp("err sticky", 32'(err3), 32'd1);
    applyStimulus(4'b0000, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1);
    cmp("err set wins", 32'(err3), 32'd1);
    applyStimulus(4'b0000, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    cmp("err cleared", 32'(err3), 32'd0);

    // Random traffic with occasional mode flips and clears
    doReset();
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(4'($urandom), $urandom, 2'($urandom),
                    ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
